output_frame_ctrl: RTL and testbench

- Output-side controller that sits directly upstream of the 40-bit serializer.
- Buffers paired left/right 40-bit filter results from the ALU stage in a small FIFO.
- On each frame sync, presents the head pair to the serializers and holds serializer enable high for exactly WORD_BITS consecutive sClk cycles, then retires the pair.
- Tracks overflow, underrun and frame-sync errors for the top-level status logic.

---
 rtl/output_frame_ctrl.sv | 80 ++++++++
 tb/tb_output_frame_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/output_frame_ctrl.sv
// output_frame_ctrl: buffers L/R result pairs and frames each pair out to the serializers on frame sync.
module output_frame_ctrl #(
    parameter int WORD_BITS = 40,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 sClk,
    input  logic                 start_n,
    input  logic [WORD_BITS-1:0] result_L,
    input  logic [WORD_BITS-1:0] result_R,
    input  logic                 result_valid,
    output logic                 result_ready,
    input  logic                 frame,
    output logic                 ser_en,
    output logic [WORD_BITS-1:0] ser_data_L,
    output logic [WORD_BITS-1:0] ser_data_R,
    output logic                 out_ready,
    output logic [CNT_W-1:0]     words_sent,
    output logic                 overflow,
    output logic                 underrun,
    output logic                 sync_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WORD_BITS);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;
    logic [WORD_BITS-1:0] mem_l [DEPTH];
    logic [WORD_BITS-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [BW-1:0] bit_cnt;
    logic full, push, last, start;
    always_comb begin
        full     = count == (PW+1)'(DEPTH);
        push     = result_valid && !full;
        last     = state == SEND && bit_cnt == BW'(WORD_BITS-1);
        start    = state == IDLE && frame && count != '0;
        state_nx = start ? SEND : last ? IDLE : state;
        ser_en   = state == SEND;
    end
    assign result_ready = !full;
    always_ff @(posedge sClk) begin
        if (push) begin
            mem_l[wr_ptr] <= result_L;
            mem_r[wr_ptr] <= result_R;
        end
    end
    always_ff @(posedge sClk) begin
        if (!start_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ser_data_L <= '0;
            ser_data_R <= '0;
            out_ready  <= 1'b0;
            words_sent <= '0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            out_ready <= ser_en;
            bit_cnt   <= (start || last) ? '0 : ser_en ? bit_cnt + 1'b1 : bit_cnt;
            wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= last ? rd_ptr + 1'b1 : rd_ptr;
            count     <= count + (PW+1)'(push) - (PW+1)'(last);
            if (start) begin
                ser_data_L <= mem_l[rd_ptr];
                ser_data_R <= mem_r[rd_ptr];
            end
            words_sent <= last ? words_sent + 1'b1 : words_sent;
            // a push refused for fullness counts as overflow even when a pop retires in the same cycle
            if (result_valid && full) overflow <= 1'b1;
            if (state == IDLE && frame && count == '0) underrun <= 1'b1;
            if (state == SEND && frame) sync_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_output_frame_ctrl.sv
// tb_output_frame_ctrl: directed stimulus checked every cycle against a queue-based model plus literal spot checks.
module tb_output_frame_ctrl;
    localparam int WB = 40;
    localparam int D  = 2;
    localparam int CW = 16;
    logic sClk = 1'b0;
    logic start_n = 1'b0;
    logic [WB-1:0] result_L = '0, result_R = '0;
    logic result_valid = 1'b0, frame = 1'b0;
    logic result_ready, ser_en, out_ready, overflow, underrun, sync_err;
    logic [WB-1:0] ser_data_L, ser_data_R;
    logic [CW-1:0] words_sent;
    output_frame_ctrl #(.WORD_BITS(WB), .DEPTH(D), .CNT_W(CW)) dut (
        .sClk(sClk), .start_n(start_n), .result_L(result_L), .result_R(result_R),
        .result_valid(result_valid), .result_ready(result_ready), .frame(frame),
        .ser_en(ser_en), .ser_data_L(ser_data_L), .ser_data_R(ser_data_R),
        .out_ready(out_ready), .words_sent(words_sent), .overflow(overflow),
        .underrun(underrun), .sync_err(sync_err)
    );
    always #5 sClk = ~sClk;
    logic [WB-1:0] q_l[$], q_r[$];
    logic [WB-1:0] m_dl, m_dr;
    logic [CW-1:0] m_ws;
    int m_rem;
    bit m_ovf, m_und, m_sync, m_or;
    int n_chk = 0, n_pass = 0, en_hi = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask
    // model: pending pairs in a queue, a send is just a countdown of remaining enabled cycles
    task automatic step();
        @(posedge sClk);
        if (!start_n) begin
            q_l.delete(); q_r.delete();
            m_rem = 0; m_dl = '0; m_dr = '0; m_ws = '0;
            m_ovf = 0; m_und = 0; m_sync = 0; m_or = 0;
        end else begin
            bit fin = m_rem == 1;
            bit go = 0;
            int sz = q_l.size();
            m_or = m_rem > 0;
            if (frame) begin
                if (m_rem > 0) m_sync = 1;
                else if (sz == 0) m_und = 1;
                else go = 1;
            end
            if (go) begin m_dl = q_l[0]; m_dr = q_r[0]; end
            if (fin) begin void'(q_l.pop_front()); void'(q_r.pop_front()); m_ws = m_ws + 1'b1; end
            if (result_valid) begin
                if (sz == D) m_ovf = 1;
                else begin q_l.push_back(result_L); q_r.push_back(result_R); end
            end
            m_rem = go ? WB : (m_rem > 0 ? m_rem - 1 : 0);
        end
        #1;
        if (ser_en) en_hi++;
        chk("ser_en", 64'(ser_en), 64'(m_rem > 0));
        chk("out_ready", 64'(out_ready), 64'(m_or));
        chk("result_ready", 64'(result_ready), 64'(q_l.size() < D));
        chk("ser_data_L", 64'(ser_data_L), 64'(m_dl));
        chk("ser_data_R", 64'(ser_data_R), 64'(m_dr));
        chk("words_sent", 64'(words_sent), 64'(m_ws));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underrun", 64'(underrun), 64'(m_und));
        chk("sync_err", 64'(sync_err), 64'(m_sync));
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic rst();
        start_n = 1'b0; result_valid = 1'b0; frame = 1'b0;
        run(2);
        start_n = 1'b1;
    endtask
    task automatic push(input logic [WB-1:0] l, input logic [WB-1:0] r);
        result_L = l; result_R = r; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
    endtask
    task automatic pulse();
        frame = 1'b1;
        step();
        frame = 1'b0;
    endtask
    initial begin
        rst();
        chk("rst_ready", 64'(result_ready), 64'd1);
        chk("rst_en", 64'(ser_en), 64'd0);
        push(40'h00_0000_0001, 40'hFF_FFFF_FFFF);
        en_hi = 0;
        pulse();
        chk("t1_data_L", 64'(ser_data_L), 64'h00_0000_0001);
        chk("t1_data_R", 64'(ser_data_R), 64'hFF_FFFF_FFFF);
        run(40);
        chk("t1_en_len", 64'(en_hi), 64'd40);
        chk("t1_en_off", 64'(ser_en), 64'd0);
        chk("t1_or_lag", 64'(out_ready), 64'd1);
        chk("t1_words", 64'(words_sent), 64'd1);
        step();
        chk("t1_or_off", 64'(out_ready), 64'd0);
        rst();
        push(40'h11_1111_1111, 40'h22_2222_2222);
        push(40'h33_3333_3333, 40'h44_4444_4444);
        chk("t2_full", 64'(result_ready), 64'd0);
        push(40'h55_5555_5555, 40'h66_6666_6666);
        chk("t2_ovf", 64'(overflow), 64'd1);
        pulse();
        chk("t2_first", 64'(ser_data_L), 64'h11_1111_1111);
        run(40);
        pulse();
        chk("t2_second", 64'(ser_data_R), 64'h44_4444_4444);
        run(40);
        chk("t2_words", 64'(words_sent), 64'd2);
        chk("t2_empty_ready", 64'(result_ready), 64'd1);
        rst();
        pulse();
        chk("t3_und", 64'(underrun), 64'd1);
        chk("t3_no_en", 64'(ser_en), 64'd0);
        push(40'h0A_BCDE_F012, 40'h34_5678_9ABC);
        pulse();
        chk("t3_send", 64'(ser_en), 64'd1);
        run(40);
        chk("t3_und_sticky", 64'(underrun), 64'd1);
        chk("t3_words", 64'(words_sent), 64'd1);
        rst();
        result_L = 40'h77_0000_0077; result_R = 40'h88_0000_0088;
        result_valid = 1'b1; frame = 1'b1;
        step();
        result_valid = 1'b0; frame = 1'b0;
        chk("t3b_und", 64'(underrun), 64'd1);
        chk("t3b_no_en", 64'(ser_en), 64'd0);
        pulse();
        chk("t3b_sent_later", 64'(ser_data_L), 64'h77_0000_0077);
        rst();
        push(40'h01_0203_0405, 40'h06_0708_090A);
        push(40'h0B_0C0D_0E0F, 40'h10_1112_1314);
        en_hi = 0;
        pulse();
        run(9);
        pulse();
        chk("t4_sync", 64'(sync_err), 64'd1);
        run(29);
        pulse();
        chk("t4_en_len", 64'(en_hi), 64'd40);
        chk("t4_no_restart", 64'(ser_en), 64'd0);
        pulse();
        chk("t4_next_word", 64'(ser_en), 64'd1);
        chk("t4_next_data", 64'(ser_data_L), 64'h0B_0C0D_0E0F);
        rst();
        push(40'hA0_A0A0_A0A0, 40'hB0_B0B0_B0B0);
        push(40'hC0_C0C0_C0C0, 40'hD0_D0D0_D0D0);
        pulse();
        run(39);
        push(40'hE0_E0E0_E0E0, 40'hF0_F0F0_F0F0);
        chk("t5_refused_ovf", 64'(overflow), 64'd1);
        chk("t5_ready_after_pop", 64'(result_ready), 64'd1);
        push(40'hE0_E0E0_E0E0, 40'hF0_F0F0_F0F0);
        chk("t5_accepted", 64'(result_ready), 64'd0);
        rst();
        push(40'h12_3456_789A, 40'hBC_DEF0_1234);
        push(40'h21_4365_87A9, 40'hCB_ED0F_2143);
        push(40'h99_9999_9999, 40'h99_9999_9999);
        pulse();
        run(19);
        start_n = 1'b0;
        step();
        chk("t6_en", 64'(ser_en), 64'd0);
        chk("t6_words", 64'(words_sent), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_ready", 64'(result_ready), 64'd1);
        start_n = 1'b1;
        step();
        pulse();
        chk("t6_fifo_empty", 64'(underrun), 64'd1);
        chk("t6_no_send", 64'(ser_en), 64'd0);
        run(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
